// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFFS_W = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
// The read register doubles as the responder's DataOut and can be cleared on a rejected access.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Contents survive reset on purpose.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle word memory responder on a Req/Ready/Ack handshake with WAIT wait states.
// Misaligned or out-of-range accesses complete with Err and never touch the array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WAIT   = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              WE,
  input  logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] DataIn,
  output logic              Ready,
  output logic              Ack,
  output logic [WORD_W-1:0] DataOut,
  output logic              Err
);

  localparam logic [WAIT_W-1:0] WaitCnt = WAIT_W'(WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ack_q, err_q;
  logic              commit, acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          we_d    = WE;
          addr_d  = Address;
          wdata_d = DataIn;
          cnt_d   = WaitCnt;
          state_d = (WaitCnt == '0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_W'(1)) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Commit uses the _d copies so a zero-wait access commits on its own acceptance edge.
  assign commit  = (state_d == StResp) && (state_q != StResp);
  assign acc_err = (addr_d[OFFS_W-1:0] != '0) || (addr_d[WORD_W-1:ADDR_W+OFFS_W] != '0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= commit;
      err_q   <= commit & acc_err;
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .we_i   (commit & we_d & ~acc_err),
    .re_i   (commit & ~we_d & ~acc_err),
    .clr_i  (commit & acc_err),
    .addr_i (addr_d[ADDR_W+OFFS_W-1:OFFS_W]),
    .wdata_i(wdata_d),
    .rdata_o(DataOut)
  );

  assign Ready = (state_q == StIdle);
  assign Ack   = ack_q;
  assign Err   = err_q;

endmodule
